// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/subtract controller that reuses one 4-bit ripple slice per cycle.
// The carry between nibbles is registered, and the result is returned on a valid/ready handshake.
module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LastIdx = IDXW'(NIB - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [IDXW+1:0]  w_base;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_nib_sum;
    logic             w_accept;
    logic             w_consume;
    logic             w_last;
    logic             w_ovf;

    assign w_accept  = in_valid && (r_state == StIdle);
    assign w_consume = out_ready && (r_state == StDone);
    assign w_last    = (r_state == StRun) && (r_idx == LastIdx);

    // Shared 4-bit slice: operand nibbles selected by the current iteration index.
    always_comb begin
        w_base    = {r_idx, 2'b00};
        w_a_nib   = r_a[w_base +: 4];
        w_b_nib   = r_b[w_base +: 4];
        w_nib_sum = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
        w_ovf     = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_nib_sum[3] != r_a[WIDTH-1]);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_accept)  w_state_nxt = StRun;
            StRun:   if (w_last)    w_state_nxt = StDone;
            StDone:  if (w_consume) w_state_nxt = StIdle;
            default:                w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is folded into the operands: A + ~B + 1.
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_idx   <= '0;
        end else if (r_state == StRun) begin
            r_sum[w_base +: 4] <= w_nib_sum[3:0];
            r_carry            <= w_nib_sum[4];
            r_idx              <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_nib_sum[4];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state == StRun) || (r_state == StDone);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
// Every result is compared against a plain-arithmetic reference model.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int failures = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic, with carry and overflow found from the mathematical result.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] r, output logic c, output logic o);
        int sa;
        int sb;
        int res;
        int ua;
        int ub;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        ua  = int'(a);
        ub  = int'(b);
        res = s ? sa - sb : sa + sb;
        o   = (res > 32767) || (res < -32768);
        r   = s ? 16'(ua - ub) : 16'(ua + ub);
        c   = s ? (ua >= ub) : ((ua + ub) > 65535);
    endfunction

    // Drives one operation and returns the observed result. lat is -1 on timeout.
    // rdy_leak is set if in_ready was seen high while the operation was in flight.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic c, output logic o,
                         output int lat, output logic rdy_leak);
        int waits;
        lat = -1;
        rdy_leak = 1'b0;
        r = '0;
        c = 1'b0;
        o = 1'b0;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) return;
        op_a = a;
        op_b = b;
        sub = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        sub = 1'($urandom);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) rdy_leak = 1'b1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) return;
        r = sum;
        c = cout;
        o = ovf;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0 ||
            cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset: rdy=%b ov=%b busy=%b sum=%h cout=%b ovf=%b required 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000,
                                16'h0000, 16'h8000, 16'hFFFF};
        logic [15:0] tb [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001,
                                16'h0000, 16'h8000, 16'hFFFF};
        logic        ts [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] er;
        logic        ec;
        logic        eo;
        logic [15:0] r;
        logic        c;
        logic        o;
        int          lat;
        logic        leak;
        for (int i = 0; i < 8; i++) begin
            model(ta[i], tb[i], ts[i], er, ec, eo);
            do_op(ta[i], tb[i], ts[i], r, c, o, lat, leak);
            checks++;
            if (lat !== 4 || leak !== 1'b0) begin
                failures++;
                $display("FAIL directed_latency[%0d]: latency=%0d rdy_leak=%b required 4 0",
                         i, lat, leak);
            end
            checks++;
            if (r !== er || c !== ec || o !== eo) begin
                failures++;
                $display("FAIL directed_result[%0d]: %h %s %h got sum=%h cout=%b ovf=%b required %h %b %b",
                         i, ta[i], ts[i] ? "-" : "+", tb[i], r, c, o, er, ec, eo);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        lat = -1;
        @(negedge clk);
        op_a = 16'h1234;
        op_b = 16'h4321;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        op_a = 16'h0003;
        op_b = 16'h0004;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL bp_latency: latency=%0d required 4", lat);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h5555 ||
                cout !== 1'b0 || ovf !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: ov=%b rdy=%b sum=%h cout=%b ovf=%b required 1 0 5555 0 0",
                         i, out_valid, in_ready, sum, cout, ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: ov=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_pending_accept: rdy=%b busy=%b required 0 1", in_ready, busy);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 4 || sum !== 16'h0007 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL bp_pending_result: latency=%0d sum=%h cout=%b ovf=%b required 4 0007 0 0",
                     lat, sum, cout, ovf);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [15:0] r;
        logic        c;
        logic        o;
        int          lat;
        logic        leak;
        @(negedge clk);
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0 || in_ready !== 1'b1 ||
            cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop: ov=%b busy=%b sum=%h rdy=%b cout=%b ovf=%b required 0 0 0000 1 0 0",
                     out_valid, busy, sum, in_ready, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0001, 16'h0001, 1'b0, r, c, o, lat, leak);
        checks++;
        if (lat !== 4 || r !== 16'h0002 || c !== 1'b0 || o !== 1'b0) begin
            failures++;
            $display("FAIL reset_recover: latency=%0d sum=%h cout=%b ovf=%b required 4 0002 0 0",
                     lat, r, c, o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r;
        logic        c;
        logic        o;
        int          lat;
        logic        leak;
        do_op(16'h00FF, 16'h0001, 1'b0, r, c, o, lat, leak);
        checks++;
        if (lat !== 4 || r !== 16'h0100 || c !== 1'b0 || o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: latency=%0d sum=%h cout=%b ovf=%b required 4 0100 0 0",
                     lat, r, c, o);
        end
        do_op(16'h0100, 16'h0001, 1'b1, r, c, o, lat, leak);
        checks++;
        if (lat !== 4 || r !== 16'h00FF || c !== 1'b1 || o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: latency=%0d sum=%h cout=%b ovf=%b required 4 00ff 1 0",
                     lat, r, c, o);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] er;
        logic        ec;
        logic        eo;
        logic [15:0] r;
        logic        c;
        logic        o;
        int          lat;
        logic        leak;
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            model(a, b, s, er, ec, eo);
            do_op(a, b, s, r, c, o, lat, leak);
            checks++;
            if (lat !== 4 || leak !== 1'b0 || r !== er || c !== ec || o !== eo) begin
                failures++;
                $display("FAIL random[%0d]: %h %s %h got lat=%0d leak=%b sum=%h cout=%b ovf=%b required 4 0 %h %b %b",
                         i, a, s ? "-" : "+", b, lat, leak, r, c, o, er, ec, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
